// File: rtl/lif_neuron_update.sv
// Leaky-integrate-and-fire update engine: serialized read-modify-write of membrane
// potentials in a single-port SRAM, driven by synaptic events and leak sweeps.
module lif_neuron_update #(
  parameter int                      WIDTH           = 32,
  parameter int                      DEPTH           = 256,
  parameter logic signed [WIDTH-1:0] THRESHOLD       = WIDTH'(1000),
  parameter logic signed [WIDTH-1:0] RESET_POTENTIAL = '0,
  parameter int                      LEAK_SHIFT      = 4,
  localparam int                     AW              = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic [AW-1:0]           ev_addr,
  input  logic signed [WIDTH-1:0] ev_weight,
  input  logic                    sweep_start,
  output logic                    busy,
  output logic                    sweep_done,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic signed [WIDTH-1:0] mem_wdata,
  input  logic signed [WIDTH-1:0] mem_rdata,
  output logic                    spk_valid,
  input  logic                    spk_ready,
  output logic [AW-1:0]           spk_addr
);

  typedef enum logic [1:0] {IDLE, READ, CALC, WRITE} state_t;

  localparam logic signed [WIDTH-1:0] MAX_V     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [AW-1:0]           LAST_ADDR = AW'(DEPTH - 1);

  state_t                  state;
  logic                    sweep_pending;
  logic                    in_sweep;
  logic signed [WIDTH-1:0] weight_q;

  logic signed [WIDTH:0]   sum;
  logic signed [WIDTH-1:0] v_sat;
  logic signed [WIDTH-1:0] v_leak;
  logic signed [WIDTH-1:0] v_new;
  logic signed [WIDTH-1:0] wr_val;
  logic                    fire;
  logic                    calc_go;

  // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
  always_comb begin
    sum    = {mem_rdata[WIDTH-1], mem_rdata} + {weight_q[WIDTH-1], weight_q};
    if (sum[WIDTH] != sum[WIDTH-1]) v_sat = sum[WIDTH] ? MIN_V : MAX_V;
    else                            v_sat = sum[WIDTH-1:0];
    v_leak = mem_rdata - (mem_rdata >>> LEAK_SHIFT);
    v_new  = in_sweep ? v_leak : v_sat;
    fire   = (v_new >= THRESHOLD);
    wr_val = fire ? RESET_POTENTIAL : v_new;
  end

  // A firing neuron may only leave CALC once the spike register is free or being drained.
  assign calc_go  = !fire || !spk_valid || spk_ready;
  assign busy     = (state != IDLE);
  assign ev_ready = (state == IDLE) && !sweep_pending;

  // NOTE: non-blocking assignments throughout; later statements in the block win,
  // which is how a new spike or sweep request overrides a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      sweep_pending <= 1'b0;
      in_sweep      <= 1'b0;
      weight_q      <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      spk_valid     <= 1'b0;
      spk_addr      <= '0;
      sweep_done    <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (spk_valid && spk_ready) spk_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (sweep_pending) begin
            sweep_pending <= 1'b0;
            in_sweep      <= 1'b1;
            mem_addr      <= '0;
            state         <= READ;
          end else if (ev_valid) begin
            in_sweep <= 1'b0;
            mem_addr <= ev_addr;
            weight_q <= ev_weight;
            state    <= READ;
          end
        end
        READ: state <= CALC;
        CALC: begin
          if (calc_go) begin
            mem_we    <= 1'b1;
            mem_wdata <= wr_val;
            if (fire) begin
              spk_valid <= 1'b1;
              spk_addr  <= mem_addr;
            end
            state <= WRITE;
          end
        end
        WRITE: begin
          mem_we <= 1'b0;
          if (in_sweep && mem_addr != LAST_ADDR) begin
            mem_addr <= mem_addr + AW'(1);
            state    <= READ;
          end else begin
            sweep_done <= in_sweep;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (sweep_start) sweep_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lif_neuron_update.sv
// Self-checking bench for lif_neuron_update: two instances (normal and near-max threshold)
// with behavioural SRAMs and an arithmetic reference model of potential updates.
module tb_lif_neuron_update;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam longint VMAX = 64'sd2147483647;
  localparam longint VMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic ev_valid [2], ev_ready [2], sweep_start [2], busy [2], sweep_done [2];
  logic mem_we [2], spk_valid [2], spk_ready [2];
  logic [AW-1:0] ev_addr [2], mem_addr [2], spk_addr [2];
  logic signed [W-1:0] ev_weight [2], mem_wdata [2], mem_rdata [2];

  logic pl_we [2];
  logic [AW-1:0] pl_addr;
  logic signed [W-1:0] pl_data;
  logic signed [W-1:0] sram [2][D];

  longint model [2][D];
  longint thr [2] = '{64'sd1000, VMAX};
  int total = 0;
  int bad = 0;

  lif_neuron_update #(.WIDTH(W), .DEPTH(D), .THRESHOLD(32'sd1000),
                      .RESET_POTENTIAL(32'sd0), .LEAK_SHIFT(4)) u_dut0 (
    .clk(clk), .reset(reset),
    .ev_valid(ev_valid[0]), .ev_ready(ev_ready[0]), .ev_addr(ev_addr[0]), .ev_weight(ev_weight[0]),
    .sweep_start(sweep_start[0]), .busy(busy[0]), .sweep_done(sweep_done[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .spk_valid(spk_valid[0]), .spk_ready(spk_ready[0]), .spk_addr(spk_addr[0])
  );

  lif_neuron_update #(.WIDTH(W), .DEPTH(D), .THRESHOLD(32'sh7fffffff),
                      .RESET_POTENTIAL(32'sd0), .LEAK_SHIFT(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .ev_valid(ev_valid[1]), .ev_ready(ev_ready[1]), .ev_addr(ev_addr[1]), .ev_weight(ev_weight[1]),
    .sweep_start(sweep_start[1]), .busy(busy[1]), .sweep_done(sweep_done[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .spk_valid(spk_valid[1]), .spk_ready(spk_ready[1]), .spk_addr(spk_addr[1])
  );

  // Synchronous-read SRAMs; the bench preload port takes priority over the DUT.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (pl_we[g])       sram[g][pl_addr]     <= pl_data;
      else if (mem_we[g]) sram[g][mem_addr[g]] <= mem_wdata[g];
      mem_rdata[g] <= sram[g][mem_addr[g]];
    end
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: saturating add for events, floor-division leak for sweeps, then threshold.
  function automatic void ref_update(input longint v, input longint w, input bit sweep,
                                     input longint th, output longint wr, output bit f);
    longint n, q;
    if (sweep) begin
      q = v / 16;
      if (v < 0 && (v % 16) != 0) q = q - 1;
      n = v - q;
    end else begin
      n = v + w;
      if (n > VMAX) n = VMAX;
      if (n < VMIN) n = VMIN;
    end
    f  = (n >= th);
    wr = f ? 64'sd0 : n;
  endfunction

  task automatic preload(input int g, input int a, input longint v);
    pl_we[g] = 1'b1;
    pl_addr  = AW'(a);
    pl_data  = W'(v);
    tick();
    pl_we[g] = 1'b0;
    model[g][a] = v;
  endtask

  task automatic check_reset(input int g);
    check("rst_mem_we", mem_we[g], 0);
    check("rst_mem_addr", mem_addr[g], 0);
    check("rst_mem_wdata", mem_wdata[g], 0);
    check("rst_spk_valid", spk_valid[g], 0);
    check("rst_spk_addr", spk_addr[g], 0);
    check("rst_sweep_done", sweep_done[g], 0);
    check("rst_busy", busy[g], 0);
    check("rst_ev_ready", ev_ready[g], 1);
  endtask

  task automatic check_mem(input int g);
    for (int a = 0; a < D; a++) check($sformatf("mem%0d[%0d]", g, a), sram[g][a], model[g][a]);
  endtask

  // Called in the cycle after the accepting edge (READ); walks through WRITE back to IDLE.
  task automatic ev_finish(input int g, input int a, input longint w);
    longint wr;
    bit f;
    ref_update(model[g][a], w, 1'b0, thr[g], wr, f);
    check("rd_busy", busy[g], 1);
    check("rd_we", mem_we[g], 0);
    check("rd_addr", mem_addr[g], a);
    check("rd_ev_ready", ev_ready[g], 0);
    tick();
    check("calc_we", mem_we[g], 0);
    tick();
    check("wr_we", mem_we[g], 1);
    check("wr_addr", mem_addr[g], a);
    check("wr_data", mem_wdata[g], wr);
    check("wr_spk_valid", spk_valid[g], f);
    if (f) check("wr_spk_addr", spk_addr[g], a);
    tick();
    check("idle_ev_ready", ev_ready[g], 1);
    check("idle_busy", busy[g], 0);
    check("idle_we", mem_we[g], 0);
    model[g][a] = wr;
  endtask

  task automatic ev_send(input int g, input int a, input longint w);
    int n = 0;
    ev_valid[g]  = 1'b1;
    ev_addr[g]   = AW'(a);
    ev_weight[g] = W'(w);
    while (!ev_ready[g] && n < 200) begin
      tick();
      n++;
    end
    check("ev_accept_timeout", n < 200, 1);
    tick();
    ev_valid[g] = 1'b0;
    if (n < 200) ev_finish(g, a, w);
  endtask

  initial begin
    longint wr;
    bit f;
    int wr_cnt, done_cnt, run, acc, a, hit;

    reset = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    for (int g = 0; g < 2; g++) begin
      ev_valid[g] = 1'b0; ev_addr[g] = '0; ev_weight[g] = '0;
      sweep_start[g] = 1'b0; spk_ready[g] = 1'b1; pl_we[g] = 1'b0;
    end
    #2;
    check_reset(0);
    check_reset(1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < D; i++) preload(g, i, longint'($urandom_range(0, 1000)) - 500);

    // Reset asserted during the WRITE of an event aborts the write.
    ev_valid[0] = 1'b1; ev_addr[0] = 4'd2; ev_weight[0] = 32'sd50;
    check("pre_ev_ready", ev_ready[0], 1);
    tick();
    ev_valid[0] = 1'b0;
    tick();
    tick();
    check("abort_wr_we", mem_we[0], 1);
    reset = 1'b0;
    #1;
    check_reset(0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_no_write", sram[0][2], model[0][2]);
    ev_send(0, 2, 50);

    // Sub-threshold event.
    preload(0, 5, 100);
    ev_send(0, 5, 200);
    check("sub_mem5", sram[0][5], 300);

    // Fire with spike backpressure; second fire stalls in CALC.
    spk_ready[0] = 1'b0;
    preload(0, 7, 900);
    preload(0, 8, 999);
    ev_send(0, 7, 150);
    check("bp_spk_hold", spk_valid[0], 1);
    check("bp_spk_addr7", spk_addr[0], 7);
    ev_valid[0] = 1'b1; ev_addr[0] = 4'd8; ev_weight[0] = 32'sd1;
    check("bp_ev_ready", ev_ready[0], 1);
    tick();
    ev_valid[0] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_we", mem_we[0], 0);
      check("stall_busy", busy[0], 1);
      check("stall_addr", mem_addr[0], 8);
      check("stall_spk_addr", spk_addr[0], 7);
    end
    spk_ready[0] = 1'b1;
    tick();
    check("bp_wr_we", mem_we[0], 1);
    check("bp_wr_addr", mem_addr[0], 8);
    check("bp_wr_data", mem_wdata[0], 0);
    check("bp_spk_valid", spk_valid[0], 1);
    check("bp_spk_addr8", spk_addr[0], 8);
    tick();
    check("bp_spk_clear", spk_valid[0], 0);
    check("bp_idle", ev_ready[0], 1);
    model[0][8] = 0;
    check_mem(0);

    // Saturation at both rails.
    preload(0, 3, VMIN + 10);
    ev_send(0, 3, -100);
    check("sat_neg_mem", sram[0][3], VMIN);
    preload(1, 4, VMAX - 10);
    ev_send(1, 4, 100);
    check("sat_pos_mem", sram[1][4], 0);

    // Leak sweep with a held event and a re-queued sweep.
    preload(0, 0, 160);
    preload(0, 1, -5);
    preload(0, 2, -1);
    preload(0, 3, 1100);
    sweep_start[0] = 1'b1;
    tick();
    sweep_start[0] = 1'b0;
    check("sw_pending_blocks", ev_ready[0], 0);
    ev_valid[0] = 1'b1; ev_addr[0] = 4'd9; ev_weight[0] = 32'sd5;
    wr_cnt = 0; done_cnt = 0; run = 0; acc = 0;
    for (int c = 0; c < 400 && acc == 0; c++) begin
      sweep_start[0] = (c == 20 || c == 30);
      if (busy[0]) run++;
      if (mem_we[0]) begin
        a = wr_cnt % D;
        ref_update(model[0][a], 0, 1'b1, thr[0], wr, f);
        check("sw_addr", mem_addr[0], a);
        check("sw_data", mem_wdata[0], wr);
        check("sw_spk_valid", spk_valid[0], f);
        if (f) check("sw_spk_addr", spk_addr[0], a);
        model[0][a] = wr;
        wr_cnt++;
      end
      if (sweep_done[0]) begin
        done_cnt++;
        check("sw_done_cycles", run, 3 * D);
        check("sw_done_busy", busy[0], 0);
        check("sw_done_writes", wr_cnt, D * done_cnt);
        run = 0;
      end
      if (ev_ready[0]) begin
        check("sw_ev_after_done", done_cnt, 2);
        acc = 1;
      end
      tick();
    end
    sweep_start[0] = 1'b0;
    ev_valid[0] = 1'b0;
    check("sw_timeout", acc, 1);
    if (acc == 1) ev_finish(0, 9, 5);
    check_mem(0);

    // Reset during the WRITE of index 1 with a further sweep queued.
    sweep_start[0] = 1'b1;
    tick();
    sweep_start[0] = 1'b0;
    hit = 0;
    for (int c = 0; c < 100 && hit == 0; c++) begin
      sweep_start[0] = (c == 2);
      if (mem_we[0] && mem_addr[0] == 4'd0) begin
        ref_update(model[0][0], 0, 1'b1, thr[0], wr, f);
        model[0][0] = wr;
      end
      if (mem_we[0] && mem_addr[0] == 4'd1) hit = 1;
      else tick();
    end
    sweep_start[0] = 1'b0;
    check("rs_reached_wr1", hit, 1);
    reset = 1'b0;
    #1;
    check_reset(0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rs_stay_idle", busy[0], 0);
      check("rs_ev_ready", ev_ready[0], 1);
    end
    check_mem(0);

    // Random events on both instances.
    for (int i = 0; i < 40; i++) begin
      int g, r;
      longint w;
      g = int'($urandom_range(0, 1));
      a = int'($urandom_range(0, D - 1));
      r = int'($urandom_range(0, 3));
      case (r)
        0: w = longint'($urandom_range(0, 1400)) - 600;
        1: w = longint'(int'($urandom()));
        2: w = VMAX;
        default: w = VMIN;
      endcase
      ev_send(g, a, w);
    end
    check_mem(0);
    check_mem(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lif_neuron_update.md
# lif_neuron_update

Leaky-integrate-and-fire update engine that owns the single port of the membrane-potential `sram` instance and sits directly upstream of it. It accepts synaptic events (target neuron, signed weight) and periodic leak-sweep commands. It performs a read-modify-write of the neuron's potential, applies saturation, leak and threshold/reset, and writes the result back. Neurons that fire are emitted on a spike output stream toward the routing stage.

## Interface
- `WIDTH`, 32: potential and weight width, signed two's complement.
- `DEPTH`, 256: number of neurons; address width is `$clog2(DEPTH)`.
- `THRESHOLD`, 1000: signed firing threshold; fire when `v_new >= THRESHOLD`.
- `RESET_POTENTIAL`, 0: value written back on fire.
- `LEAK_SHIFT`, 4: leak step is `v - (v >>> LEAK_SHIFT)`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `ev_valid`, in, 1: synaptic event present.
- `ev_ready`, out, 1: event accepted on the edge where `ev_valid && ev_ready`.
- `ev_addr`, in, AW: target neuron.
- `ev_weight`, in, WIDTH signed: weight to add.
- `sweep_start`, in, 1: one-cycle pulse requesting a leak sweep.
- `busy`, out, 1: FSM not in IDLE.
- `sweep_done`, out, 1: one-cycle pulse after the last sweep write.
- `mem_we`, out, 1: drives `sram.write_enable`.
- `mem_addr`, out, AW: drives `sram.addr`.
- `mem_wdata`, out, WIDTH signed: drives `sram.write_word`.
- `mem_rdata`, in, WIDTH signed: from `sram.word`, valid one cycle after `mem_addr` is presented.
- `spk_valid`, out, 1: spike pending.
- `spk_ready`, in, 1: spike consumed on the edge where `spk_valid && spk_ready`.
- `spk_addr`, out, AW: neuron that fired.

## Operation
- FSM states: IDLE, READ, CALC, WRITE. `mem_we`, `mem_addr`, `mem_wdata`, `spk_*` and `sweep_done` are registered outputs.
- `ev_ready` is high only in IDLE with no sweep pending.
- `sweep_start` sets `sweep_pending` in any state. A pulse during a sweep queues exactly one further sweep.
- From IDLE, a pending sweep has priority over events. The sweep clears `sweep_pending`, sets index 0 and goes to READ.
- From IDLE, an accepted event latches `ev_addr` and `ev_weight` and goes to READ.
- READ: `mem_addr` holds the target and `mem_we` is 0. Next state is CALC.
- CALC: `mem_rdata` is valid and `v_new` is computed.
  - Event: `v_new = sat(v + w)`, where the sum is computed at WIDTH+1 bits and clamped to [-2^(W-1), 2^(W-1)-1].
  - Sweep: `v_new = v - (v >>> LEAK_SHIFT)`; this cannot overflow.
  - If `v_new >= THRESHOLD` (signed), the write value is `RESET_POTENTIAL` and a spike is raised; otherwise the write value is `v_new`.
- Fire while `spk_valid` is still unaccepted: the FSM stays in CALC. Address is unchanged and no write occurs, so `mem_rdata` stays stable. It proceeds on the edge where the old spike is accepted.
- WRITE: `mem_we` is 1 for exactly one cycle with `mem_addr` and `mem_wdata`.
  - Event: next state is IDLE.
  - Sweep: if index < DEPTH-1, increment index and go to READ; else pulse `sweep_done` and go to IDLE.
- Spike register: `spk_valid` and `spk_addr` are set at the CALC→WRITE edge and cleared on handshake.
- Reset (async, any state): FSM goes to IDLE and `sweep_pending` is cleared. An in-flight write is aborted and never reaches the SRAM.
  - Reset values: `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `spk_valid` 0, `spk_addr` 0, `sweep_done` 0, `busy` 0, `ev_ready` 1.
  - SRAM contents are not touched by this block.

## Timing
- Event accepted at the edge ending cycle 0:
  - cycle 1: READ.
  - cycle 2: CALC, `mem_rdata` valid.
  - cycle 3: WRITE, `mem_we`=1, and `spk_valid` rises if the neuron fired.
  - cycle 4: IDLE, `ev_ready`=1.
- Throughput is one event per 4 cycles; read-after-write hazards are impossible because updates are serialized.
- Sweep: 3 cycles per neuron plus stall cycles. `sweep_done` is high in the cycle after the last WRITE; with no stalls that is 3·DEPTH cycles after leaving IDLE.
- `busy` is high from READ through WRITE; it is low in the `sweep_done` cycle.

## Test plan
- Reset: hold `reset`=0 mid-event → all outputs at their reset values immediately and `ev_ready`=1. Release, then send an event to neuron 2 → the normal 4-cycle sequence follows.
- Sub-threshold event: mem[5]=100, event (5, +200) → `mem_we`=1 with addr 5 and wdata 300 in cycle 3, `spk_valid` stays 0, `ev_ready`=1 in cycle 4.
- Fire with backpressure: `spk_ready`=0, then:
  - mem[7]=900, event (7, +150) → wdata 0 and `spk_valid`/`spk_addr`=7 in cycle 3.
  - mem[8]=999, event (8, +1) → FSM holds in CALC with no write.
  - Raise `spk_ready` → mem[8] written 0 and `spk_addr`=8.
- Saturation: mem[3]=-2^31+10, event (3, -100) → wdata -2^31, no spike. mem[4]=2^31-10 with THRESHOLD=2^31-1, event (4, +100) → wdata 0 and spike on neuron 4.
- Leak sweep, DEPTH=4, LEAK_SHIFT=4, mem={160, -5, -1, 1100}:
  - writes are 150, -4, 0 and 0; spike on neuron 3 (1032 ≥ 1000); `sweep_done` pulses 12 cycles after start.
  - An `ev_valid` held during the sweep is accepted only after `sweep_done`.
  - A second `sweep_start` mid-sweep triggers exactly one more sweep.
- Reset mid-sweep: assert reset during WRITE of index 1 → no write to index 1, `sweep_pending` cleared, FSM in IDLE after release.
